// File: rtl/serial_pkg.sv
// Definitions shared by the serial link state machines (tx_fsm / rx_fsm):
// word geometry and the common state encoding.
package serial_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_DONE  = 3'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, plus a rising-edge
// detect on the synchronised level (one extra register).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            s_d   <= chain[STAGES-1];
        end
    end

    assign s    = chain[STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/rx_fsm.sv
// Receive side of the serial link: deserialises one MSB-first word per frame.
// Optional frame watchdog built when RX_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for a latch rise with rx_en high
// ST_SHIFT | capturing bits on sck rises
// ST_DONE  | word complete, one cycle, then back to idle
module rx_fsm
    import serial_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              sck_rx,
    input  logic              data_rx,
    input  logic              latch_rx,
    output logic [WORD_W-1:0] received_data,
    output logic              finish,
    output logic              busy,
    output logic              frame_err
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [WORD_W-1:0] shreg, shreg_next, rdata_next;
    logic              sck_rise, latch_rise, data_s;
    logic              sck_s_unused, latch_s_unused, data_rise_unused;
    logic              abort, timeout;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck_rx), .s(sck_s_unused), .rise(sck_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst(rst), .d(data_rx), .s(data_s), .rise(data_rise_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .rst(rst), .d(latch_rx), .s(latch_s_unused), .rise(latch_rise)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;

    // Down-counter reloaded on frame (re)start and on every captured bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_next == ST_SHIFT &&
                     (state != ST_SHIFT || latch_rise || sck_rise)) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES);
        end else if (state == ST_SHIFT && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout = (tmr == '0);
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            shreg         <= '0;
            received_data <= '0;
            finish        <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            shreg         <= shreg_next;
            received_data <= rdata_next;
            finish        <= (state == ST_DONE);
            frame_err     <= abort;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        rdata_next = received_data;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_en && latch_rise) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                    shreg_next = '0;
                end
            end
            ST_SHIFT: begin
                // A latch rise wins over a coincident sck rise.
                if (latch_rise) begin
                    abort      = 1'b1;
                    cnt_next   = '0;
                    shreg_next = '0;
                end else if (sck_rise) begin
                    shreg_next = {shreg[WORD_W-2:0], data_s};
                    cnt_next   = cnt + 1'b1;
                    if (cnt == CNT_W'(WORD_W - 1)) begin
                        rdata_next = {shreg[WORD_W-2:0], data_s};
                        state_next = ST_DONE;
                    end
                end else if (timeout) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SHIFT) || (state == ST_DONE);

endmodule

// File: tb/tb_rx_fsm.sv
// Self-checking bench for rx_fsm: pin-level frame driver, a bit-counting
// reference model compared every cycle, and directed literal expectations.
module tb_rx_fsm;

    localparam int S = 2;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en = 1'b0;
    logic        sck_rx = 1'b0;
    logic        data_rx = 1'b0;
    logic        latch_rx = 1'b0;
    logic [31:0] received_data;
    logic        finish, busy, frame_err;

    rx_fsm #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .sck_rx(sck_rx),
        .data_rx(data_rx), .latch_rx(latch_rx),
        .received_data(received_data), .finish(finish),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int printed = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 40) begin
                $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
                printed++;
            end
        end
    endtask

    // Reference model: pins seen S cycles late, bits counted to 32.
    logic        hl[0:S] = '{default: 1'b0};
    logic        hs[0:S] = '{default: 1'b0};
    logic        hd[0:S] = '{default: 1'b0};
    int          m_phase = 0;   // 0 waiting, 1 receiving, 2 just completed
    int          m_bits = 0;
    int          m_idle = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_rdata = '0;
    logic        m_fin = 1'b0;
    logic        m_err = 1'b0;
    logic        model_valid = 1'b0;

    task automatic model_step();
        logic lr, sr, d;
        if (rst) begin
            for (int i = 0; i <= S; i++) begin
                hl[i] = 1'b0; hs[i] = 1'b0; hd[i] = 1'b0;
            end
            m_phase = 0; m_bits = 0; m_idle = 0;
            m_word = '0; m_rdata = '0; m_fin = 1'b0; m_err = 1'b0;
        end else begin
            lr = hl[S-1] & ~hl[S];
            sr = hs[S-1] & ~hs[S];
            d  = hd[S-1];
            m_fin = (m_phase == 2);
            m_err = 1'b0;
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (rx_en && lr) begin
                    m_phase = 1; m_bits = 0; m_idle = 0; m_word = '0;
                end
            end else if (lr) begin
                m_err = 1'b1; m_bits = 0; m_idle = 0; m_word = '0;
            end else if (sr) begin
                m_word = m_word * 2 + {31'b0, d};
                m_bits++;
                m_idle = 0;
                if (m_bits == 32) begin
                    m_rdata = m_word; m_phase = 2; m_bits = 0;
                end
            end
`ifdef RX_TIMEOUT_EN
            else if (m_idle == T) begin
                m_err = 1'b1; m_phase = 0;
            end else begin
                m_idle++;
            end
`endif
            for (int i = S; i > 0; i--) begin
                hl[i] = hl[i-1]; hs[i] = hs[i-1]; hd[i] = hd[i-1];
            end
            hl[0] = latch_rx; hs[0] = sck_rx; hd[0] = data_rx;
        end
        model_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare plus event bookkeeping for the directed checks.
    int          fin_cnt = 0;
    int          err_cnt = 0;
    int          finish_cyc = 0;
    int          last_rise_cyc = 0;
    logic        busy_seen = 1'b0;
    logic [31:0] fin_q[$];

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            chk("cyc_finish", {31'b0, finish}, {31'b0, m_fin});
            chk("cyc_frame_err", {31'b0, frame_err}, {31'b0, m_err});
            chk("cyc_busy", {31'b0, busy}, {31'b0, (m_phase != 0)});
            chk("cyc_received_data", received_data, m_rdata);
            if (finish === 1'b1) begin
                fin_cnt++;
                fin_q.push_back(received_data);
                finish_cyc = cyc;
            end
            if (frame_err === 1'b1) err_cnt++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        fin_cnt = 0; err_cnt = 0; busy_seen = 1'b0; fin_q.delete();
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits);
        latch_rx = 1'b1; tick(2);
        latch_rx = 1'b0; tick(2);
        for (int i = 0; i < nbits; i++) begin
            data_rx = w[31-i]; sck_rx = 1'b0; tick(2);
            sck_rx = 1'b1; last_rise_cyc = cyc; tick(2);
        end
        sck_rx = 1'b0; data_rx = 1'b0; tick(2);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        return (fin_q.size() > idx) ? fin_q[idx] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        tick(3);
        chk("rst_received_data", received_data, 32'h0);
        chk("rst_finish", {31'b0, finish}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'h0);
        rst = 1'b0;
        tick(4);

        // Disabled receiver ignores a complete frame.
        clear_counts();
        rx_en = 1'b0;
        send_frame(32'h0F0F_0F0F, 32);
        tick(10);
        chk("dis_finish_count", fin_cnt, 0);
        chk("dis_received_data", received_data, 32'h0);
        chk("dis_busy_seen", {31'b0, busy_seen}, 32'h0);

        // Single frame, value and pin-to-finish latency.
        clear_counts();
        rx_en = 1'b1;
        send_frame(32'd1_456_478_547, 32);
        tick(10);
        chk("one_finish_count", fin_cnt, 1);
        chk("one_received_data", received_data, 32'h56D0_1953);
        chk("one_latency", finish_cyc - last_rise_cyc, S + 2);
        chk("one_frame_err_count", err_cnt, 0);

        // Back-to-back frames.
        clear_counts();
        send_frame(32'hFFFF_FFFF, 32);
        send_frame(32'h0000_0001, 32);
        tick(10);
        chk("b2b_finish_count", fin_cnt, 2);
        chk("b2b_word0", q_at(0), 32'hFFFF_FFFF);
        chk("b2b_word1", q_at(1), 32'h0000_0001);
        chk("b2b_frame_err_count", err_cnt, 0);

        // Resynchronisation after a partial frame.
        clear_counts();
        send_frame(32'hDEAD_BEEF, 10);
        send_frame(32'hA5A5_A5A5, 32);
        tick(10);
        chk("resync_frame_err_count", err_cnt, 1);
        chk("resync_finish_count", fin_cnt, 1);
        chk("resync_received_data", received_data, 32'hA5A5_A5A5);

        // Reset mid-frame, then a clean frame.
        clear_counts();
        send_frame(32'hCAFE_F00D, 20);
        rst = 1'b1;
        tick(1);
        chk("midrst_received_data", received_data, 32'h0);
        chk("midrst_finish", {31'b0, finish}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_frame_err", {31'b0, frame_err}, 32'h0);
        rst = 1'b0;
        tick(4);
        chk("midrst_no_events", fin_cnt + err_cnt, 0);
        send_frame(32'h1234_5678, 32);
        tick(10);
        chk("postrst_finish_count", fin_cnt, 1);
        chk("postrst_received_data", received_data, 32'h1234_5678);
        chk("postrst_frame_err_count", err_cnt, 0);

`ifdef RX_TIMEOUT_EN
        // Stalled sck aborts the frame.
        clear_counts();
        send_frame(32'hFFFF_0000, 5);
        tick(100);
        chk("tmo_frame_err_count", err_cnt, 1);
        chk("tmo_busy", {31'b0, busy}, 32'h0);
        chk("tmo_finish_count", fin_cnt, 0);
        chk("tmo_received_data", received_data, 32'h1234_5678);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
